// File: rtl/uart_receiver.sv
// 16x-oversampling UART receive stage (8N1, LSB first) with a held-valid/ack output.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_receiver #(
   parameter int DVSR      = 11,
   parameter int WORD_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 nRST,
   input  logic                 serialIn,
   output logic [WORD_SIZE-1:0] dataOut,
   output logic                 dataValid,
   input  logic                 dataAck,
   output logic                 frameErr,
   output logic                 overrun
);

   localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;
   localparam int NW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

   state_t               state, stateNext;
   logic                 syncMeta, rxs;
   logic [TW-1:0]        tickCnt;
   logic                 tick;
   logic [3:0]           s;
   logic [NW-1:0]        n;
   logic [WORD_SIZE-1:0] shiftReg;
   logic                 parErr;

   logic alignTick, clrS, clrN, incN, shiftEn, loadWord, frameErrSet;
`ifdef UART_RX_PARITY_EN
   logic capPar, parBit;
   // even parity: data bits plus parity bit must hold an even number of ones
   assign parErr = ^{shiftReg, parBit};
`else
   assign parErr = 1'b0;
`endif

   assign tick = (tickCnt == TW'(DVSR - 1));

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext   = state;
      alignTick   = 1'b0;
      clrS        = 1'b0;
      clrN        = 1'b0;
      incN        = 1'b0;
      shiftEn     = 1'b0;
      loadWord    = 1'b0;
      frameErrSet = 1'b0;
`ifdef UART_RX_PARITY_EN
      capPar      = 1'b0;
`endif
      case (state)
         IDLE: if (!rxs) begin
            stateNext = START;
            alignTick = 1'b1;
            clrS      = 1'b1;
         end
         START: if (tick && s == 4'd7) begin
            clrS = 1'b1;
            if (!rxs) begin
               stateNext = DATA;
               clrN      = 1'b1;
            end else begin
               stateNext = IDLE;
            end
         end
         DATA: if (tick && s == 4'd15) begin
            clrS    = 1'b1;
            shiftEn = 1'b1;
            if (n == NW'(WORD_SIZE - 1))
`ifdef UART_RX_PARITY_EN
               stateNext = PARITY;
`else
               stateNext = STOP;
`endif
            else
               incN = 1'b1;
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (tick && s == 4'd15) begin
            clrS      = 1'b1;
            capPar    = 1'b1;
            stateNext = STOP;
         end
`endif
         STOP: if (tick && s == 4'd15) begin
            clrS = 1'b1;
            if (!rxs) begin
               frameErrSet = 1'b1;
               stateNext   = BREAK;
            end else if (parErr) begin
               frameErrSet = 1'b1;
               stateNext   = IDLE;
            end else begin
               loadWord  = 1'b1;
               stateNext = IDLE;
            end
         end
         BREAK: if (rxs) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         syncMeta  <= 1'b1;
         rxs       <= 1'b1;
         tickCnt   <= '0;
         s         <= '0;
         n         <= '0;
         shiftReg  <= '0;
         dataOut   <= '0;
         dataValid <= 1'b0;
         frameErr  <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parBit    <= 1'b0;
`endif
      end else begin
         syncMeta <= serialIn;
         rxs      <= syncMeta;

         // restart the divider on the falling edge so samples land mid-bit
         if (alignTick || tick) tickCnt <= '0;
         else                   tickCnt <= tickCnt + 1'b1;

         if (clrS)      s <= '0;
         else if (tick) s <= s + 4'd1;

         if (clrN)      n <= '0;
         else if (incN) n <= n + 1'b1;

         if (shiftEn) shiftReg <= {rxs, shiftReg[WORD_SIZE-1:1]};
`ifdef UART_RX_PARITY_EN
         if (capPar) parBit <= rxs;
`endif

         frameErr <= frameErrSet;
         overrun  <= 1'b0;
         if (loadWord) begin
            dataOut   <= shiftReg;
            dataValid <= 1'b1;
            overrun   <= dataValid && !dataAck;
         end else if (dataAck) begin
            dataValid <= 1'b0;
         end
      end
   end

endmodule
